// File: rtl/fu_rr_arbiter_pkg.sv
// Shared types for the round-robin functional-unit arbiter.
package fu_rr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } ARB_STATE;

endpackage

// File: rtl/fu_rr_arbiter_pselect.sv
// Rotating priority selector: the first set req bit, starting at sel, wins.
// DIR=0 scans upward from sel (sel, sel+1, ...); DIR=1 scans downward.
module pselect #(
  parameter int N   = 8,
  parameter bit DIR = 1'b0
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] sel,
  input  logic                 en,
  output logic [N-1:0]         gnt
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] idx;

  // N is a power of two, so the index arithmetic wraps naturally at IW bits.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = DIR ? (sel - IW'(k)) : (sel + IW'(k));
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fu_rr_arbiter.sv
// Round-robin arbiter sharing one functional unit among N requesters, with
// occupancy tracking for multi-cycle ops.
//
//   state    | meaning
//   ARB_IDLE | FU free; grants allowed when fu_ready=1 and flush=0
//   ARB_BUSY | FU occupied by a multi-cycle op; cnt counts down to 1
module fu_rr_arbiter
  import fu_rr_arbiter_pkg::*;
#(
  parameter int N     = 8,
  parameter int LAT_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 fu_ready,
  input  logic [LAT_W-1:0]     busy_cycles,
  input  logic                 flush,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic [$clog2(N)-1:0] ptr,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  ARB_STATE         state;
  ARB_STATE         state_nxt;
  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] cnt_nxt;
  logic [IW-1:0]    ptr_nxt;
  logic             grant_allowed;

  // reset is folded in so the grant drops the moment reset asserts.
  assign grant_allowed = (state == ARB_IDLE) && fu_ready && !flush && reset;

  pselect #(
    .N   (N),
    .DIR (1'b0)
  ) u_pselect (
    .req (req),
    .sel (ptr),
    .en  (grant_allowed),
    .gnt (gnt)
  );

  assign gnt_valid = |gnt;
  assign busy      = (state == ARB_BUSY);

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = gnt_idx | IW'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    if (flush) begin
      state_nxt = ARB_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (gnt_valid) begin
            ptr_nxt = gnt_idx + IW'(1);
            if (busy_cycles != '0) begin
              state_nxt = ARB_BUSY;
              cnt_nxt   = busy_cycles;
            end
          end
        end
        ARB_BUSY: begin
          cnt_nxt = cnt - LAT_W'(1);
          // <= 1 also recovers from a stray cnt of 0 instead of wrapping.
          if (cnt <= LAT_W'(1)) begin
            state_nxt = ARB_IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ARB_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_fu_rr_arbiter.sv
// Directed bench for fu_rr_arbiter: rotation, occupancy, flush, backpressure
// and asynchronous reset, with hand-computed expectations.
module tb_fu_rr_arbiter;

  logic       clock;
  logic       reset;
  logic [7:0] req;
  logic       fu_ready;
  logic [2:0] busy_cycles;
  logic       flush;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [2:0] ptr;
  logic       busy;

  int total = 0;
  int bad   = 0;

  fu_rr_arbiter #(
    .N     (8),
    .LAT_W (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .fu_ready    (fu_ready),
    .busy_cycles (busy_cycles),
    .flush       (flush),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_idx     (gnt_idx),
    .ptr         (ptr),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    req         = 8'hFF;
    fu_ready    = 1'b1;
    busy_cycles = 3'd0;
    flush       = 1'b0;

    // reset held: outputs quiet regardless of req
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_gvalid", 32'(gnt_valid), 0);
    chk("rst_gidx", 32'(gnt_idx), 0);
    chk("rst_ptr", 32'(ptr), 0);
    chk("rst_busy", 32'(busy), 0);

    // release and rotate through all eight requesters
    reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("rot_gnt", 32'(gnt), 32'(1) << i);
      chk("rot_gidx", 32'(gnt_idx), 32'(i));
      chk("rot_ptr", 32'(ptr), 32'(i));
      tick();
    end
    chk("rot_wrap_ptr", 32'(ptr), 0);

    // two requesters alternate 0,7,0,7
    req = 8'b1000_0001;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("two_gnt", 32'(gnt), (i % 2 == 0) ? 32'h01 : 32'h80);
      chk("two_gidx", 32'(gnt_idx), (i % 2 == 0) ? 0 : 7);
      tick();
    end
    chk("two_ptr", 32'(ptr), 0);

    // occupancy: busy_cycles=3 blocks three cycles
    req         = 8'h0F;
    busy_cycles = 3'd3;
    #1;
    chk("occ_gnt_t", 32'(gnt), 32'h01);
    tick();
    busy_cycles = 3'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("occ_busy", 32'(busy), 1);
      chk("occ_gnt_blk", 32'(gnt), 0);
      tick();
    end
    chk("occ_busy_end", 32'(busy), 0);
    chk("occ_ptr", 32'(ptr), 1);
    chk("occ_gnt_t4", 32'(gnt), 32'h02);
    tick();
    chk("occ_ptr2", 32'(ptr), 2);

    // flush in the middle of a 5-cycle op
    busy_cycles = 3'd5;
    #1;
    chk("fl_gnt_t", 32'(gnt), 32'h04);
    tick();
    busy_cycles = 3'd0;
    #1;
    chk("fl_busy_t1", 32'(busy), 1);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_gnt_t2", 32'(gnt), 0);
    chk("fl_busy_t2", 32'(busy), 1);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_busy_t3", 32'(busy), 0);
    chk("fl_ptr_t3", 32'(ptr), 3);
    chk("fl_gnt_t3", 32'(gnt), 32'h08);
    tick();
    req = 8'h02;
    #1;
    chk("fl_gnt_wrap", 32'(gnt), 32'h02);
    tick();
    chk("fl_ptr_end", 32'(ptr), 2);

    // flush while idle: no grant, ptr holds
    req   = 8'hFF;
    flush = 1'b1;
    #1;
    chk("fli_gnt", 32'(gnt), 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fli_ptr", 32'(ptr), 2);

    // backpressure: fu_ready low holds everything
    req      = 8'h10;
    fu_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_gnt", 32'(gnt), 0);
      chk("bp_ptr", 32'(ptr), 2);
      tick();
    end
    fu_ready = 1'b1;
    #1;
    chk("bp_gnt_rel", 32'(gnt), 32'h10);
    chk("bp_gidx_rel", 32'(gnt_idx), 4);
    tick();
    chk("bp_ptr_rel", 32'(ptr), 5);

    // busy ignores fu_ready; async reset with cnt=4
    req         = 8'hFF;
    busy_cycles = 3'd5;
    #1;
    chk("ar_gnt_t", 32'(gnt), 32'h20);
    tick();
    busy_cycles = 3'd0;
    fu_ready    = 1'b0;
    tick();
    fu_ready    = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 1);
    chk("ar_gnt_blk", 32'(gnt), 0);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_busy_rst", 32'(busy), 0);
    chk("ar_ptr_rst", 32'(ptr), 0);
    chk("ar_gnt_rst", 32'(gnt), 0);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_gnt_rel", 32'(gnt), 32'h01);
    tick();
    chk("ar_ptr_rel", 32'(ptr), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
